project_decoder: RTL

Inverse (decoder) companion to the team's 4-input/3-output `project` encoder. Given a 3-bit code XYZ, the block scans all sixteen 4-bit inputs ABCD in order and streams every input the encoder maps to that code through a valid/ready output port. It then reports completion and the number of preimages found. It sits beside the encoder in the lab design, for round-trip checking and display of all inputs that produce a given code.

---
 rtl/project_decoder.sv | 115 +++++++++++
 1 files changed

// File: rtl/project_decoder.sv
// project_decoder: the inverse of the 4-in/3-out `project` encoder.
// Given a target code it walks every input 0..15 in order and streams each
// input that encodes to that code over a valid/ready port. When the walk is
// finished it pulses `done` and reports how many inputs matched.
module project_decoder (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] code_in,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_abcd,
   output logic       busy,
   output logic       done,
   output logic [2:0] match_count,
   output logic       no_match
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_HOLD,
      S_DONE
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [3:0] idx;      // candidate input {A,B,C,D}
   logic [2:0] count;    // matches found so far in this scan
   logic [2:0] code_q;   // target code, frozen for the whole scan
   logic       hit;
   logic       last;

   // Forward encoder: {A,B,C,D} -> {X,Y,Z}
   function automatic logic [2:0] encode(input logic [3:0] v);
      logic a, b, c, d, x, y, z;
      a = v[3];
      b = v[2];
      c = v[1];
      d = v[0];
      x = a & b & (c | d);
      y = (a ^ b) | (b & ~c & ~d) | (~a & c & d);
      z = (a & ~b) | (a & ~c & ~d) | (~b & (c ^ d)) | (~a & b & c & d);
      return {x, y, z};
   endfunction

   assign hit  = (encode(idx) == code_q);
   // The walk ends explicitly at the last candidate; idx never wraps.
   assign last = (idx == 4'd15);

   // Next-state logic
   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch is inferred.
      state_next = state;
      case (state)
         S_IDLE: if (start) state_next = S_SCAN;
         S_SCAN: begin
            if (hit)       state_next = S_HOLD;
            else if (last) state_next = S_DONE;
         end
         S_HOLD: begin
            if (out_ready) state_next = last ? S_DONE : S_SCAN;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Scan datapath: candidate index, match counter, latched code, output data
   always_ff @(posedge clk) begin
      if (rst) begin
         idx      <= 4'd0;
         count    <= 3'd0;
         code_q   <= 3'd0;
         out_abcd <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  code_q <= code_in;
                  idx    <= 4'd0;
                  count  <= 3'd0;
               end
            end
            S_SCAN: begin
               if (hit)        out_abcd <= idx;
               else if (!last) idx      <= idx + 4'd1;
            end
            S_HOLD: begin
               // The edge with out_ready high is the transfer.
               if (out_ready) begin
                  count <= count + 3'd1;
                  if (!last) idx <= idx + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Status outputs decode registered state only, so no input reaches them combinationally.
   assign out_valid   = (state == S_HOLD);
   assign busy        = (state != S_IDLE);
   assign done        = (state == S_DONE);
   assign match_count = count;
   assign no_match    = done & (count == 3'd0);

endmodule
